// File: rtl/rr_arbiter8.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter8
//  Description : Eight-way round-robin arbiter with registered one-hot grant,
//                matching grant index, and a hold limit that forces rotation
//                when other requesters are waiting.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter8 #(
    parameter int HOLD_MAX = 16
) (
    input  logic       i_CLK,
    input  logic       i_RST_N,
    input  logic       i_EN,
    input  logic [7:0] i_REQ,
    output logic [7:0] i_GNT,
    output logic [2:0] i_GNT_IDX,
    output logic       i_GNT_VLD
);

    // Last hold count value at which a waiting contender forces rotation.
    localparam logic [7:0] HOLD_LAST = (HOLD_MAX == 0) ? 8'd0 : 8'(HOLD_MAX - 1);
    localparam bit         HOLD_ON   = (HOLD_MAX != 0);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] idx;
    logic [2:0] idx_nxt;
    logic [2:0] ptr;
    logic [2:0] ptr_nxt;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;

    logic       scan_found;
    logic [2:0] scan_idx;
    logic [2:0] scan_cand;
    logic [7:0] owner_mask;
    logic       owner_released;
    logic       others_pending;
    logic       preempt;

    // Rotating priority search: first set request at ptr, ptr+1, ... (mod 8).
    // Walking offsets from high to low lets the lowest offset win last.
    always_comb begin
        scan_found = 1'b0;
        scan_idx   = ptr;
        scan_cand  = ptr;
        for (int k = 7; k >= 0; k--) begin
            scan_cand = ptr + 3'(k);
            if (i_REQ[scan_cand]) begin
                scan_found = 1'b1;
                scan_idx   = scan_cand;
            end
        end
    end

    // Owner release and hold-limit preemption conditions.
    always_comb begin
        owner_mask     = 8'b1 << idx;
        owner_released = ~i_REQ[idx];
        others_pending = |(i_REQ & ~owner_mask);
        preempt        = HOLD_ON && (cnt == HOLD_LAST) && others_pending;
    end

    // Next-state logic; every owner change detours through IDLE so the
    // grant bus always shows one zero cycle between owners.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (i_EN && scan_found) begin
                    state_nxt = S_GRANT;
                    idx_nxt   = scan_idx;
                    cnt_nxt   = 8'd0;
                end
            end
            S_GRANT: begin
                if (owner_released || preempt) begin
                    state_nxt = S_IDLE;
                    // The departing owner becomes lowest priority next scan.
                    ptr_nxt   = idx + 3'd1;
                end else if (cnt != 8'hFF) begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State registers; asynchronous reset drops any grant immediately.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state <= S_IDLE;
            idx   <= 3'd0;
            ptr   <= 3'd0;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Outputs decode straight from registers, so the grant is glitch-free
    // and can never be multi-hot.
    always_comb begin
        i_GNT_VLD = (state == S_GRANT);
        i_GNT_IDX = idx;
        i_GNT     = i_GNT_VLD ? (8'b1 << idx) : 8'b0;
    end

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter8.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_arbiter8
//  Description : Self-checking bench for rr_arbiter8; one instance with a
//                hold limit of 4 and one with no limit share the stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rr_arbiter8;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic [7:0] req   = 8'h00;

    logic [7:0] gnt_a;
    logic [2:0] idx_a;
    logic       vld_a;
    logic [7:0] gnt_b;
    logic [2:0] idx_b;
    logic       vld_b;

    rr_arbiter8 #(.HOLD_MAX(4)) dut_h4 (
        .i_CLK     (clk),
        .i_RST_N   (rst_n),
        .i_EN      (en),
        .i_REQ     (req),
        .i_GNT     (gnt_a),
        .i_GNT_IDX (idx_a),
        .i_GNT_VLD (vld_a)
    );

    rr_arbiter8 #(.HOLD_MAX(0)) dut_h0 (
        .i_CLK     (clk),
        .i_RST_N   (rst_n),
        .i_EN      (en),
        .i_REQ     (req),
        .i_GNT     (gnt_b),
        .i_GNT_IDX (idx_b),
        .i_GNT_VLD (vld_b)
    );

    // Clock generation.
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: owner number (-1 = nobody), last index shown,
    // cycles held, and next starting point of the search.
    int hold_of [2] = '{4, 0};
    int m_owner [2];
    int m_last  [2];
    int m_cnt   [2];
    int m_ptr   [2];

    typedef struct packed {
        logic [7:0] req;
        logic       en;
        logic [7:0] gnt;
        logic       vld;
        logic [2:0] idx;
    } vec_t;

    vec_t tbl [0:17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=0x%0h required=0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic chk_dut(input string tag, input int d, input logic [7:0] eg,
                           input logic ev, input logic [2:0] ei);
        logic [7:0] g;
        logic       v;
        logic [2:0] i;
        string      sfx;
        if (d == 0) begin
            g = gnt_a; v = vld_a; i = idx_a; sfx = "h4";
        end else begin
            g = gnt_b; v = vld_b; i = idx_b; sfx = "h0";
        end
        chk($sformatf("%s[%s] gnt", tag, sfx), 32'(g), 32'(eg));
        chk($sformatf("%s[%s] vld", tag, sfx), 32'(v), 32'(ev));
        chk($sformatf("%s[%s] idx", tag, sfx), 32'(i), 32'(ei));
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_owner[d] = -1;
            m_last[d]  = 0;
            m_cnt[d]   = 0;
            m_ptr[d]   = 0;
        end
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step(input int d);
        int         o;
        int         c;
        bit         found;
        logic [7:0] others;
        o = m_owner[d];
        if (o < 0) begin
            if (en && req != 8'h00) begin
                found = 1'b0;
                for (int k = 0; k < 8; k++) begin
                    c = (m_ptr[d] + k) % 8;
                    if (!found && req[c]) begin
                        found      = 1'b1;
                        m_owner[d] = c;
                        m_last[d]  = c;
                        m_cnt[d]   = 0;
                    end
                end
            end
        end else begin
            others = req & ~(8'(1) << o);
            if (!req[o] || (hold_of[d] != 0 && m_cnt[d] == hold_of[d] - 1 && others != 8'h00)) begin
                m_ptr[d]   = (o + 1) % 8;
                m_owner[d] = -1;
            end else if (m_cnt[d] < 255) begin
                m_cnt[d] = m_cnt[d] + 1;
            end
        end
    endtask

    task automatic model_check(input string tag);
        logic [7:0] eg;
        for (int d = 0; d < 2; d++) begin
            eg = (m_owner[d] < 0) ? 8'h00 : (8'(1) << m_owner[d]);
            chk_dut(tag, d, eg, (m_owner[d] >= 0), 3'(m_last[d]));
        end
    endtask

    // One clock: model sees the same inputs as the DUTs, outputs sampled 1ns later.
    task automatic tick();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 8'h00;
        en    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        chk_dut("reset", 0, 8'h00, 1'b0, 3'd0);
        chk_dut("reset", 1, 8'h00, 1'b0, 3'd0);
    endtask

    // Stimulus and checking.
    initial begin
        logic [7:0] eg;
        logic [2:0] ei;
        int         k;

        // Fairness between 0 and 7, wrap from 7 to 0, single grant/release,
        // and enable gating, all from a fresh reset.
        tbl[0]  = '{req: 8'h81, en: 1'b1, gnt: 8'h01, vld: 1'b1, idx: 3'd0};
        tbl[1]  = '{req: 8'h80, en: 1'b1, gnt: 8'h00, vld: 1'b0, idx: 3'd0};
        tbl[2]  = '{req: 8'h81, en: 1'b1, gnt: 8'h80, vld: 1'b1, idx: 3'd7};
        tbl[3]  = '{req: 8'h01, en: 1'b1, gnt: 8'h00, vld: 1'b0, idx: 3'd7};
        tbl[4]  = '{req: 8'h81, en: 1'b1, gnt: 8'h01, vld: 1'b1, idx: 3'd0};
        tbl[5]  = '{req: 8'h80, en: 1'b1, gnt: 8'h00, vld: 1'b0, idx: 3'd0};
        tbl[6]  = '{req: 8'h81, en: 1'b1, gnt: 8'h80, vld: 1'b1, idx: 3'd7};
        tbl[7]  = '{req: 8'h01, en: 1'b1, gnt: 8'h00, vld: 1'b0, idx: 3'd7};
        tbl[8]  = '{req: 8'hFF, en: 1'b1, gnt: 8'h01, vld: 1'b1, idx: 3'd0};
        tbl[9]  = '{req: 8'hFE, en: 1'b1, gnt: 8'h00, vld: 1'b0, idx: 3'd0};
        tbl[10] = '{req: 8'hFF, en: 1'b1, gnt: 8'h02, vld: 1'b1, idx: 3'd1};
        tbl[11] = '{req: 8'hFD, en: 1'b1, gnt: 8'h00, vld: 1'b0, idx: 3'd1};
        tbl[12] = '{req: 8'h04, en: 1'b1, gnt: 8'h04, vld: 1'b1, idx: 3'd2};
        tbl[13] = '{req: 8'h00, en: 1'b1, gnt: 8'h00, vld: 1'b0, idx: 3'd2};
        tbl[14] = '{req: 8'h00, en: 1'b1, gnt: 8'h00, vld: 1'b0, idx: 3'd2};
        tbl[15] = '{req: 8'h08, en: 1'b0, gnt: 8'h00, vld: 1'b0, idx: 3'd2};
        tbl[16] = '{req: 8'h08, en: 1'b1, gnt: 8'h08, vld: 1'b1, idx: 3'd3};
        tbl[17] = '{req: 8'h00, en: 1'b1, gnt: 8'h00, vld: 1'b0, idx: 3'd3};

        do_reset();
        for (int i = 0; i < 18; i++) begin
            req = tbl[i].req;
            en  = tbl[i].en;
            tick();
            chk_dut($sformatf("vec%0d", i), 0, tbl[i].gnt, tbl[i].vld, tbl[i].idx);
            chk_dut($sformatf("vec%0d", i), 1, tbl[i].gnt, tbl[i].vld, tbl[i].idx);
        end

        // Hold limit: 4 cycles each, one zero cycle between owners; no limit
        // keeps requester 0 forever.
        do_reset();
        en  = 1'b1;
        req = 8'h03;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            tick();
            k  = (cyc - 1) % 10;
            eg = (k < 4) ? 8'h01 : (k == 4) ? 8'h00 : (k < 9) ? 8'h02 : 8'h00;
            ei = (k < 5) ? 3'd0 : 3'd1;
            chk_dut("preempt", 0, eg, (eg != 8'h00), ei);
            chk_dut("nolimit", 1, 8'h01, 1'b1, 3'd0);
        end

        // Sole requester is never preempted; enable gates new grants only.
        do_reset();
        en  = 1'b1;
        req = 8'h10;
        for (int cyc = 0; cyc < 300; cyc++) begin
            tick();
            chk_dut("sole", 0, 8'h10, 1'b1, 3'd4);
            chk_dut("sole", 1, 8'h10, 1'b1, 3'd4);
        end
        req = 8'h00;
        tick();
        chk_dut("sole_rel", 0, 8'h00, 1'b0, 3'd4);
        en  = 1'b0;
        req = 8'h08;
        for (int cyc = 0; cyc < 3; cyc++) begin
            tick();
            chk_dut("en_off", 0, 8'h00, 1'b0, 3'd4);
            chk_dut("en_off", 1, 8'h00, 1'b0, 3'd4);
        end
        en = 1'b1;
        tick();
        chk_dut("en_on", 0, 8'h08, 1'b1, 3'd3);
        chk_dut("en_on", 1, 8'h08, 1'b1, 3'd3);

        // Asynchronous reset in the middle of a grant.
        do_reset();
        en  = 1'b1;
        req = 8'h20;
        tick();
        chk_dut("pre_arst", 0, 8'h20, 1'b1, 3'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk_dut("arst", 0, 8'h00, 1'b0, 3'd0);
        chk_dut("arst", 1, 8'h00, 1'b0, 3'd0);
        req = 8'hFF;
        #1;
        rst_n = 1'b1;
        model_reset();
        tick();
        chk_dut("post_arst", 0, 8'h01, 1'b1, 3'd0);
        chk_dut("post_arst", 1, 8'h01, 1'b1, 3'd0);

        // Randomized traffic against the reference model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 7))
                0:       req = 8'h00;
                1:       req = 8'(1) << $urandom_range(0, 7);
                2, 3:    req = 8'($urandom);
                default: req = req;
            endcase
            en = ($urandom_range(0, 9) != 0);
            tick();
            model_check("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
